// File: rtl/mat_vec_pkg.sv
// Shared types and constants for the 8x8 matrix-vector MAC controller.
package mat_vec_pkg;

  localparam int unsigned BYTE_WIDTH = 8;
  localparam int unsigned DIM        = 8;
  localparam int unsigned ACC_WIDTH  = 3 * BYTE_WIDTH;
  localparam int unsigned MAT_BYTES  = DIM * DIM;
  localparam int unsigned IDX_W      = $clog2(MAT_BYTES);
  localparam int unsigned COL_W      = $clog2(DIM);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD_A,
    PUSH_A,
    LOAD_B,
    WAIT,
    CAPTURE,
    DRAIN
  } ctrl_state_t;

endpackage

// File: rtl/mat_transpose_buf.sv
// 64-entry byte buffer: row-major write port, 8-wide column read port.
module mat_transpose_buf
  import mat_vec_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [COL_W-1:0]      rd_col,
  output logic [DATA_WIDTH-1:0] rd_data [DIM-1:0]
);

  logic [DATA_WIDTH-1:0] mem [DIM][DIM];

  // Upper index bits select the row, lower bits the column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(DIM); r++) begin
        for (int c = 0; c < int'(DIM); c++) begin
          mem[r][c] <= '0;
        end
      end
    end else if (wr_en) begin
      mem[wr_idx[IDX_W-1:COL_W]][wr_idx[COL_W-1:0]] <= wr_data;
    end
  end

  always_comb begin
    for (int r = 0; r < int'(DIM); r++) begin
      rd_data[r] = mem[r][rd_col];
    end
  end

endmodule

// File: rtl/mat_vec_ctrl.sv
// Job controller for the 8x8 matrix-vector MAC array: load, transpose, push, wait, drain.
// Optional WAIT-state watchdog enabled by defining MVC_TIMEOUT_EN.
module mat_vec_ctrl #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned DIM            = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    Clr,
  output logic                    a_wren,
  output logic [DATA_WIDTH-1:0]   a_fifo_in [DIM-1:0],
  output logic                    b_wren,
  output logic [DATA_WIDTH-1:0]   b_fifo_in,
  input  logic                    done,
  input  logic [3*DATA_WIDTH-1:0] mac_out [DIM-1:0],
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [3*DATA_WIDTH-1:0] res_data,
  output logic                    res_last,
  output logic                    busy,
  output logic                    err
);
  import mat_vec_pkg::*;

  localparam int unsigned RES_W = 3 * DATA_WIDTH;

  if (DIM != 8) begin : g_dim_check
    $error("mat_vec_ctrl: DIM must be 8");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_check
    $error("mat_vec_ctrl: TIMEOUT_CYCLES must be non-zero");
  end

  ctrl_state_t           state, next_state;
  logic [IDX_W-1:0]      cnt;
  logic                  done_q;
  logic                  accept, handshake, cnt_inc, timeout;
  logic [DATA_WIDTH-1:0] col_data [DIM-1:0];
  logic [RES_W-1:0]      res_reg  [DIM-1:0];

  assign accept    = in_valid & in_ready;
  assign handshake = res_valid & res_ready;
  assign cnt_inc   = accept | (state == PUSH_A) | handshake;

  mat_transpose_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept && (state == LOAD_A)),
    .wr_idx  (cnt),
    .wr_data (in_data),
    .rd_col  (cnt[COL_W-1:0]),
    .rd_data (col_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (in_valid) next_state = CLEAR;
      CLEAR:   next_state = LOAD_A;
      LOAD_A:  if (accept && cnt == IDX_W'(MAT_BYTES - 1)) next_state = PUSH_A;
      PUSH_A:  if (cnt == IDX_W'(DIM - 1)) next_state = LOAD_B;
      LOAD_B:  if (accept && cnt == IDX_W'(DIM - 1)) next_state = WAIT;
      // Only a rising edge of done counts; a level present on entry is ignored.
      WAIT: begin
        if (done && !done_q) next_state = CAPTURE;
        else if (timeout)    next_state = IDLE;
      end
      CAPTURE: next_state = DRAIN;
      DRAIN:   if (handshake && cnt == IDX_W'(DIM - 1)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    Clr       = 1'b0;
    busy      = 1'b1;
    res_valid = 1'b0;
    res_last  = 1'b0;
    res_data  = '0;
    unique case (state)
      IDLE:           busy = 1'b0;
      CLEAR:          Clr = 1'b1;
      LOAD_A, LOAD_B: in_ready = 1'b1;
      DRAIN: begin
        res_valid = 1'b1;
        res_data  = res_reg[cnt[COL_W-1:0]];
        res_last  = (cnt == IDX_W'(DIM - 1));
      end
      default: ;
    endcase
  end

  // Shared counter: byte index, column, vector index or result index, cleared on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      done_q    <= 1'b0;
      a_wren    <= 1'b0;
      b_wren    <= 1'b0;
      b_fifo_in <= '0;
      for (int i = 0; i < int'(DIM); i++) begin
        a_fifo_in[i] <= '0;
        res_reg[i]   <= '0;
      end
    end else begin
      done_q <= done;
      a_wren <= (state == PUSH_A);
      b_wren <= accept && (state == LOAD_B);
      if (state == PUSH_A) a_fifo_in <= col_data;
      if (accept && state == LOAD_B) b_fifo_in <= in_data;
      if (state == CAPTURE) res_reg <= mac_out;
      if (next_state != state) cnt <= '0;
      else if (cnt_inc)        cnt <= cnt + IDX_W'(1);
    end
  end

`ifdef MVC_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wait_cnt;

  assign timeout = (state == WAIT) && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog counts WAIT cycles; err is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (state != WAIT) wait_cnt <= '0;
      else               wait_cnt <= wait_cnt + TW'(1);
      if (timeout) err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_mat_vec_ctrl.sv
// Randomised self-checking bench for mat_vec_ctrl with a behavioural product model.
module tb_mat_vec_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned DN = 8;
  localparam int unsigned AW = 3 * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          clr, a_wren, b_wren;
  logic [DW-1:0] a_fifo_in [DN-1:0];
  logic [DW-1:0] b_fifo_in;
  logic          done;
  logic [AW-1:0] mac_out [DN-1:0];
  logic          res_valid, res_ready, res_last, busy, err;
  logic [AW-1:0] res_data;

  int total = 0;
  int bad   = 0;

  int unsigned   mat [64];
  int unsigned   vec [8];
  logic [AW-1:0] exp_res [8];

  logic [63:0]   a_cols [$];
  logic [DW-1:0] b_seq  [$];
  int            res_valid_cycles;
  int            clr_cycles;
  logic [63:0]   col_word;

  always #5 clk = ~clk;

  mat_vec_ctrl #(.DATA_WIDTH(DW), .DIM(DN), .TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .Clr       (clr),
    .a_wren    (a_wren),
    .a_fifo_in (a_fifo_in),
    .b_wren    (b_wren),
    .b_fifo_in (b_fifo_in),
    .done      (done),
    .mac_out   (mac_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_last  (res_last),
    .busy      (busy),
    .err       (err)
  );

  // Observe the FIFO write side and control pulses on the inactive edge.
  always @(negedge clk) begin
    if (a_wren) begin
      for (int i = 0; i < 8; i++) col_word[i*8 +: 8] = a_fifo_in[i];
      a_cols.push_back(col_word);
    end
    if (b_wren) b_seq.push_back(b_fifo_in);
    if (res_valid) res_valid_cycles++;
    if (clr) clr_cycles++;
  end

  function automatic logic any_output();
    logic any;
    any = in_ready | clr | a_wren | b_wren | res_valid | res_last | busy | err
        | (|b_fifo_in) | (|res_data);
    for (int i = 0; i < 8; i++) any = any | (|a_fifo_in[i]);
    return any;
  endfunction

  // Reference: y[i] = sum_j A[i][j] * v[j], full precision.
  task automatic compute_ref();
    for (int i = 0; i < 8; i++) begin
      int unsigned s = 0;
      for (int j = 0; j < 8; j++) s += mat[i*8 + j] * vec[j];
      exp_res[i] = AW'(s);
    end
  endtask

  task automatic randomize_job();
    for (int i = 0; i < 64; i++) mat[i] = $urandom_range(255);
    for (int i = 0; i < 8; i++)  vec[i] = $urandom_range(255);
  endtask

  task automatic start_job();
    a_cols.delete();
    b_seq.delete();
    res_valid_cycles = 0;
    clr_cycles = 0;
  endtask

  // Offer nbytes of the job stream; gap_pct is the chance of an idle cycle.
  task automatic feed(input int gap_pct, input int nbytes);
    int n = 0;
    int cyc = 0;
    logic acc;
    while (n < nbytes && cyc < 5000) begin
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = (n < 64) ? DW'(mat[n]) : DW'(vec[n - 64]);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) n++;
      cyc++;
    end
    in_valid = 1'b0;
    total++;
    if (n != nbytes) begin
      bad++;
      $display("FAIL feed_bytes got=%0d exp=%0d", n, nbytes);
    end
  endtask

  task automatic wait_b_done();
    int cyc = 0;
    while (b_seq.size() < 8 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Check FIFO pushes, answer with the model product, drain and check the results.
  task automatic finish_job(input int stall_k, input int done_delay);
    int got = 0;
    int cyc = 0;
    bit stalled = 0;
    wait_b_done();
    total++;
    if (a_cols.size() != 8) begin
      bad++;
      $display("FAIL a_wren_count got=%0d exp=8", a_cols.size());
    end
    total++;
    if (b_seq.size() != 8) begin
      bad++;
      $display("FAIL b_wren_count got=%0d exp=8", b_seq.size());
    end
    for (int c = 0; c < 8 && c < a_cols.size(); c++) begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (a_cols[c][i*8 +: 8] !== DW'(mat[i*8 + c])) begin
          bad++;
          $display("FAIL a_col%0d_row%0d got=%0h exp=%0h", c, i, a_cols[c][i*8 +: 8], mat[i*8 + c]);
        end
      end
    end
    for (int j = 0; j < 8 && j < b_seq.size(); j++) begin
      total++;
      if (b_seq[j] !== DW'(vec[j])) begin
        bad++;
        $display("FAIL b_data%0d got=%0h exp=%0h", j, b_seq[j], vec[j]);
      end
    end
    total++;
    if (clr_cycles != 1) begin
      bad++;
      $display("FAIL clr_pulses got=%0d exp=1", clr_cycles);
    end
    compute_ref();
    for (int i = 0; i < 8; i++) mac_out[i] = exp_res[i];
    repeat (done_delay) @(posedge clk);
    #1;
    done = 1'b1;
    res_ready = 1'b1;
    while (got < 8 && cyc < 500) begin
      if (got == stall_k && !stalled && res_valid) begin
        res_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          total++;
          if (res_valid !== 1'b1 || res_data !== exp_res[stall_k]) begin
            bad++;
            $display("FAIL stall_hold got=%0b/%0h exp=1/%0h", res_valid, res_data, exp_res[stall_k]);
          end
          @(posedge clk); #1;
        end
        res_ready = 1'b1;
        stalled = 1;
      end
      @(negedge clk);
      if (res_valid && res_ready) begin
        total++;
        if (res_data !== exp_res[got] || res_last !== (got == 7)) begin
          bad++;
          $display("FAIL result%0d got=%0h last=%0b exp=%0h last=%0b",
                   got, res_data, res_last, exp_res[got], (got == 7));
        end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    res_ready = 1'b0;
    done = 1'b0;
    total++;
    if (got != 8) begin
      bad++;
      $display("FAIL result_count got=%0d exp=8", got);
    end
    total++;
    if (busy !== 1'b0 || err !== 1'b0 || res_valid_cycles < 8) begin
      bad++;
      $display("FAIL job_end busy=%0b err=%0b valid_cycles=%0d exp busy=0 err=0 valid_cycles>=8",
               busy, err, res_valid_cycles);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if (any_output() !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got=1 exp=0 (busy=%0b in_ready=%0b)", busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset got busy=%0b in_ready=%0b exp=0/0", busy, in_ready);
    end
  endtask

  task automatic test_identity();
    for (int i = 0; i < 64; i++) mat[i] = ((i / 8) == (i % 8)) ? 1 : 0;
    for (int i = 0; i < 8; i++)  vec[i] = i + 1;
    start_job();
    feed(0, 72);
    finish_job(-1, 1);
  endtask

  task automatic test_all_ff();
    for (int i = 0; i < 64; i++) mat[i] = 255;
    for (int i = 0; i < 8; i++)  vec[i] = 255;
    start_job();
    feed(0, 72);
    compute_ref();
    total++;
    if (exp_res[0] !== 24'h07F008) begin
      bad++;
      $display("FAIL ff_model got=%0h exp=7f008", exp_res[0]);
    end
    finish_job(-1, 3);
  endtask

  task automatic test_random_gaps();
    for (int r = 0; r < 3; r++) begin
      randomize_job();
      start_job();
      feed(50, 72);
      finish_job(-1, $urandom_range(1, 4));
    end
  endtask

  task automatic test_drain_stall();
    randomize_job();
    start_job();
    feed(20, 72);
    finish_job(3, 2);
  endtask

  task automatic test_reset_mid();
    randomize_job();
    start_job();
    feed(0, 30);
    rst_n = 1'b0;
    #1;
    total++;
    if (any_output() !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_outputs got=1 exp=0 (busy=%0b in_ready=%0b)", busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    randomize_job();
    start_job();
    feed(30, 72);
    finish_job(-1, 2);
  endtask

  task automatic test_done_level();
    randomize_job();
    start_job();
    done = 1'b1;
    feed(0, 72);
    wait_b_done();
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (res_valid_cycles != 0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL done_level got valid_cycles=%0d busy=%0b exp=0/1", res_valid_cycles, busy);
    end
    done = 1'b0;
    @(posedge clk); #1;
    finish_job(-1, 2);
  endtask

`ifdef MVC_TIMEOUT_EN
  task automatic test_timeout();
    randomize_job();
    start_job();
    feed(0, 72);
    wait_b_done();
    repeat (8) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_early got busy=%0b err=%0b exp=1/0", busy, err);
    end
    repeat (22) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || err !== 1'b1 || res_valid_cycles != 0) begin
      bad++;
      $display("FAIL timeout got busy=%0b err=%0b valid_cycles=%0d exp=0/1/0",
               busy, err, res_valid_cycles);
    end
  endtask
`else
  task automatic test_long_wait();
    randomize_job();
    start_job();
    feed(0, 72);
    finish_job(-1, 40);
  endtask
`endif

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    done      = 1'b0;
    res_ready = 1'b0;
    for (int i = 0; i < 8; i++) mac_out[i] = '0;
    test_reset();
    test_identity();
    test_all_ff();
    test_random_gaps();
    test_drain_stall();
    test_reset_mid();
    test_done_level();
`ifdef MVC_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
